// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO feeding the UART transmitter.
// Host side writes with we/din; the transmitter pops with re/empty and latches
// the registered dout one cycle later. Count-based occupancy tracking.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   din, we, full  - write data, write request, full flag (count == DEPTH)
//   re, dout       - read request, registered read data
//   empty          - count == 0
//   count          - stored words, 0..DEPTH
//   overflow       - one-cycle pulse after a rejected write
//   underflow      - one-cycle pulse after a rejected read
module uart_tx_fifo #(
  parameter int unsigned WORD_WIDTH = 32'd8,
  parameter int unsigned DEPTH_LOG2 = 32'd4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] din,
  input  logic                  we,
  output logic                  full,
  input  logic                  re,
  output logic [WORD_WIDTH-1:0] dout,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;
  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 32'd1;

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic                  rd;
  logic                  wr;

  // Flags decode the count register only, never the same-cycle requests.
  assign empty = (count == CW'(0));
  assign full  = (count == CW'(DEPTH));

  // A read accepted while full frees the slot for a simultaneous write.
  assign rd = re & ~empty;
  assign wr = we & (~full | rd);

  // Pointers, count, registered read data and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      dout      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (rd) begin
        dout <= mem[rptr];
        rptr <= rptr + AW'(1);
      end
      if (wr) begin
        wptr <= wptr + AW'(1);
      end
      count     <= count + CW'(wr) - CW'(rd);
      overflow  <= we & ~wr;
      underflow <= re & empty;
    end
  end

  // Storage is not reset; the nonblocking write gives read-before-write on
  // the shared slot when full with simultaneous read and write.
  always_ff @(posedge clk) begin
    if (!rst && wr) begin
      mem[wptr] <= din;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int unsigned WW    = 8;
  localparam int unsigned DL    = 4;
  localparam int          DEPTH = 16;

  logic          clk;
  logic          rst;
  logic [WW-1:0] din;
  logic          we;
  logic          full;
  logic          re;
  logic [WW-1:0] dout;
  logic          empty;
  logic [DL:0]   count;
  logic          overflow;
  logic          underflow;

  uart_tx_fifo #(.WORD_WIDTH(WW), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst), .din(din), .we(we), .full(full), .re(re),
    .dout(dout), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cnt;
    logic [7:0]  dat;
    bit          ovf;
    bit          udf;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_q[$];
  logic [7:0] model_dout;
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         n_wr   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural model: a bounded queue of words with plain accept rules.
  task automatic step(input bit r, input bit w, input bit rr, input logic [7:0] d);
    exp_t e;
    int   sz;
    bit   do_rd, do_wr;
    rst = r; we = w; re = rr; din = d;
    sz  = model_q.size();
    e.ovf = 1'b0;
    e.udf = 1'b0;
    if (r) begin
      model_q.delete();
      model_dout = '0;
    end else begin
      do_rd = rr && (sz > 0);
      do_wr = w && ((sz < DEPTH) || do_rd);
      if (do_rd) model_dout = model_q.pop_front();
      if (do_wr) begin
        model_q.push_back(d);
        n_wr++;
      end
      e.ovf = w && !do_wr;
      e.udf = rr && (sz == 0);
    end
    e.cnt = model_q.size();
    e.dat = model_dout;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: pops the expected post-edge state and compares every output.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) continue;
      e = exp_q.pop_front();
      chk("count",     32'(count),     32'(e.cnt));
      chk("empty",     32'(empty),     32'(e.cnt == 0));
      chk("full",      32'(full),      32'(e.cnt == DEPTH));
      chk("dout",      32'(dout),      32'(e.dat));
      chk("overflow",  32'(overflow),  32'(e.ovf));
      chk("underflow", 32'(underflow), 32'(e.udf));
    end
  end

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; din = '0;
    model_dout = '0;
    // Reset, with requests that must be ignored, then idle.
    step(1, 0, 0, 8'h00);
    step(1, 1, 1, 8'h77);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 8'h00);
    // Fill 0x00..0x0F, overflow attempt, drain.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'(i));
    step(0, 1, 0, 8'hAA);
    step(0, 0, 0, 8'h00);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);
    // Underflow on empty.
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);
    // Full with simultaneous read and write.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'(8'h80 + i));
    step(0, 1, 1, 8'h55);
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 1, 8'h00);
    // Empty with simultaneous read and write: no fall-through.
    step(0, 1, 1, 8'h33);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);
    // Random traffic with alternating bias so the FIFO fills and drains.
    for (int i = 0; i < 400; i++) begin
      int wb, rb;
      wb = ((i / 40) % 2 == 0) ? 75 : 30;
      rb = ((i / 40) % 2 == 0) ? 30 : 75;
      step(0, $urandom_range(0, 99) < wb, $urandom_range(0, 99) < rb,
           8'($urandom));
    end
    // Mid-operation reset discards contents.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'($urandom));
    step(1, 1, 1, 8'h12);
    step(0, 0, 1, 8'h00);
    step(0, 1, 0, 8'h9C);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);
    @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
